fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port among NREQ producers. It sits directly in front of the FIFO and drives its `wr_en`/`data_in` from the winning requester. It observes `full` to stall. A bounded burst lock lets one producer issue up to MAXBURST back-to-back writes before ownership rotates.

## Interface
- NREQ, 4, number of requesters (2..16)
- DWIDTH, 8, data width; must match the FIFO DWIDTH
- MAXBURST, 4, maximum consecutive writes per ownership (1..255); 1 = pure per-word round robin
- clk  input  1  rising-edge clock, shared with the FIFO
- rst_n  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester write request; bit i = requester i
- req_data  input  NREQ*DWIDTH  flattened data; requester i occupies bits [i*DWIDTH +: DWIDTH]
- gnt  output  NREQ  one-hot-or-zero accept strobe; data of requester i is written on the edge where gnt[i]=1
- fifo_full  input  1  FIFO `full`
- fifo_wr_en  output  1  to FIFO `wr_en`; equals OR of gnt
- fifo_data_in  output  DWIDTH  to FIFO `data_in`; granted requester's data, zero when no grant
- owner  output  clog2(NREQ)  current burst owner (valid when busy=1)
- busy  output  1  1 while in BURST state

## Operation
- Registered state: `state` (IDLE, BURST), `owner`, `last` (last winner index), and `cnt` (writes in current burst, 8 bits).
- Round-robin pick: the first i with req[i]=1, searching from last+1 upward and wrapping modulo NREQ. The previous winner is checked last.
- IDLE:
  - If fifo_full=1 or req=0: no grant, stay in IDLE.
  - Otherwise, grant the pick p, set last<=p, owner<=p, cnt<=1.
  - Next state is BURST if MAXBURST>1, else IDLE.
- BURST, owner still requesting (req[owner]=1):
  - If fifo_full=1: no grant. State, cnt and owner hold (stall, ownership kept).
  - Otherwise, grant owner and set cnt<=cnt+1. If cnt+1==MAXBURST, next state is IDLE; else stay in BURST.
- BURST, owner dropped (req[owner]=0): the burst ends in that same cycle. IDLE rules are applied combinationally in that cycle, so there is no bubble and a new pick may be granted.
- At most one gnt bit is high per cycle. gnt is always 0 while fifo_full=1.
- Producer rule: hold req and req_data stable until the cycle in which gnt is seen high. After that, deassert req or present the next word.
- An empty req vector never grants, and data is never written while full. The FIFO overflow guard is therefore redundant but harmless.

## Timing
- gnt, fifo_wr_en and fifo_data_in are combinational from req, req_data, fifo_full and the registered state: zero-cycle latency from request to accept.
- State, owner, last and cnt update on the rising clk edge.
- Reset (asynchronous assert, synchronous release by the system):
  - state=IDLE, cnt=0, owner=0, last=NREQ-1 (requester 0 has first priority).
  - busy=0, owner=0.
  - gnt=0, fifo_wr_en=0 and fifo_data_in=0 for as long as rst_n=0.
- Reset mid-burst abandons the burst with no partial effect. The FIFO is reset by the same rst network.
- Wrap-around: a search from last=NREQ-1 starts at index 0. cnt never exceeds MAXBURST.
- fifo_full rising in the same cycle as a burst's final word: no grant. The burst completes on the next non-full cycle.
- Sustained throughput is one write per cycle while any requester is active and the FIFO is not full.

## Test plan
1. Reset behaviour, NREQ=4, MAXBURST=4. Hold rst_n=0 with req=4'b1111 -> gnt=0 and fifo_wr_en=0. Release rst_n -> first grant is 4'b0001 and owner=0.
2. Round-robin fairness, MAXBURST=1, all four requesters held high for 8 cycles -> gnt sequence 1,2,4,8,1,2,4,8. fifo_data_in tracks each requester's data; no idle cycles.
3. Burst lock, MAXBURST=4, req=4'b0011 held -> requester 0 granted 4 consecutive cycles, then requester 1 for 4 cycles, then requester 0. busy=1 during bursts.
4. Full stall, MAXBURST=4, requester 2 alone. Assert fifo_full for 3 cycles after its 2nd write -> gnt=0 and cnt=2 held. Deassert full -> 2 more writes, then re-arbitration; total of 4 writes in the burst.
5. Owner drop, MAXBURST=4. Requester 1 drops req after 2 writes while requester 3 waits -> requester 3 is granted in the very cycle req[1] falls (no bubble).
6. Reset mid-burst: assert rst_n=0 after 2 writes of a 4-write burst -> outputs are 0 immediately. After release, the grant starts from requester 0 with cnt=1, and the FIFO count matches the accepted words.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter sharing one FIFO write port among NREQ
//   producers. A producer that wins may keep ownership for up to MAXBURST
//   back-to-back writes. Grant is combinational (zero-cycle accept).
// Ports
//   clk, rst_n    : clock, async active-low reset
//   req           : per-requester write request
//   req_data      : flattened data, requester i at [i*DWIDTH +: DWIDTH]
//   gnt           : one-hot-or-zero accept strobe
//   fifo_full     : FIFO full, stalls all grants
//   fifo_wr_en    : FIFO write enable (OR of gnt)
//   fifo_data_in  : granted data, zero when no grant
//   owner         : current burst owner (valid while busy)
//   busy          : high while in a burst
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 4,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_data_in,
  output logic [IW-1:0]            owner,
  output logic                     busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                        state;
  logic [IW-1:0]                 last;
  logic [7:0]                    cnt;
  logic [NREQ-1:0][DWIDTH-1:0]   words;
  logic [IW-1:0]                 pick, idx, win;
  logic                          pick_vld, hold_burst, grant;

  assign words = req_data;

  // Search offsets NREQ..1 so the smallest offset from last+1 is written
  // last and wins; offset NREQ is the previous winner itself (lowest prio).
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Owner still requesting keeps the port; if it dropped, fall through to a
  // fresh pick in the same cycle so there is no bubble.
  assign hold_burst = (state == BURST) && req[owner];

  always_comb begin
    grant = 1'b0;
    win   = owner;
    if (rst_n) begin
      if (hold_burst) begin
        grant = !fifo_full;
      end else if (!fifo_full && pick_vld) begin
        grant = 1'b1;
        win   = pick;
      end
    end
  end

  assign gnt          = grant ? (NREQ'(1) << win) : '0;
  assign fifo_wr_en   = grant;
  assign fifo_data_in = grant ? words[win] : '0;
  assign busy         = (state == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      owner <= '0;
      last  <= IW'(NREQ - 1);
    end else if (hold_burst) begin
      // full stalls with state/cnt/owner held
      if (grant) begin
        cnt <= cnt + 8'd1;
        if (cnt + 8'd1 == 8'(MAXBURST)) state <= IDLE;
      end
    end else if (grant) begin
      last  <= pick;
      owner <= pick;
      cnt   <= 8'd1;
      state <= (MAXBURST > 1) ? BURST : IDLE;
    end else begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Instance a: NREQ=4, MAXBURST=4.
// Instance b: NREQ=4, MAXBURST=1 (pure round robin). Requester i of
// instance a presents 8'hA0+i, of instance b 8'hB0+i.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_a = '0, req_b = '0;
  logic        full_a = 1'b0, full_b = 1'b0;
  logic [31:0] data_a = 32'hA3A2A1A0, data_b = 32'hB3B2B1B0;
  logic [3:0]  gnt_a, gnt_b;
  logic        wr_a, wr_b, busy_a, busy_b;
  logic [7:0]  din_a, din_b;
  logic [1:0]  own_a, own_b;
  int          n_chk = 0, n_fail = 0;
  int          fifo_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8), .MAXBURST(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_data(data_a), .gnt(gnt_a),
    .fifo_full(full_a), .fifo_wr_en(wr_a), .fifo_data_in(din_a),
    .owner(own_a), .busy(busy_a));

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8), .MAXBURST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(data_b), .gnt(gnt_b),
    .fifo_full(full_b), .fifo_wr_en(wr_b), .fifo_data_in(din_b),
    .owner(own_b), .busy(busy_b));

  // Stand-in for the FIFO occupancy of instance a (reset by the same net).
  always @(posedge clk or negedge rst_n)
    if (!rst_n) fifo_cnt <= 0;
    else if (wr_a) fifo_cnt <= fifo_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_a = '0; req_b = '0; full_a = 0; full_b = 0;
    rst_n = 0; tick(); rst_n = 1; #1;
  endtask

  initial begin
    // 1. reset behaviour
    rst_n = 0; req_a = 4'b1111; #1;
    chk("rst_gnt", 32'(gnt_a), 0);
    chk("rst_wr", 32'(wr_a), 0);
    chk("rst_din", 32'(din_a), 0);
    tick();
    chk("rst_gnt_hold", 32'(gnt_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_owner", 32'(own_a), 0);
    rst_n = 1; #1;
    chk("rel_gnt", 32'(gnt_a), 32'h1);
    chk("rel_owner", 32'(own_a), 0);
    chk("rel_din", 32'(din_a), 32'hA0);

    // 2. pure round robin, MAXBURST=1
    do_reset();
    req_b = 4'b1111; #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_gnt%0d", k), 32'(gnt_b), 32'(1 << (k % 4)));
      chk($sformatf("rr_din%0d", k), 32'(din_b), 32'hB0 + 32'(k % 4));
      chk($sformatf("rr_wr%0d", k), 32'(wr_b), 1);
      chk($sformatf("rr_busy%0d", k), 32'(busy_b), 0);
      tick();
    end

    // 3. burst lock, two requesters
    do_reset();
    req_a = 4'b0011; #1;
    for (int k = 0; k < 9; k++) begin
      int w;
      w = (k >= 4 && k < 8) ? 1 : 0;
      chk($sformatf("bl_gnt%0d", k), 32'(gnt_a), 32'(1 << w));
      chk($sformatf("bl_din%0d", k), 32'(din_a), 32'hA0 + 32'(w));
      chk($sformatf("bl_busy%0d", k), 32'(busy_a), (k % 4 != 0) ? 1 : 0);
      if (k % 4 != 0) chk($sformatf("bl_own%0d", k), 32'(own_a), 32'(w));
      tick();
    end

    // 4. full stall after 2nd write, burst still totals 4
    do_reset();
    req_a = 4'b0100; #1;
    for (int k = 0; k < 8; k++) begin
      full_a = (k >= 2 && k <= 4); #1;
      if (k >= 2 && k <= 4) begin
        chk($sformatf("fs_gnt%0d", k), 32'(gnt_a), 0);
        chk($sformatf("fs_wr%0d", k), 32'(wr_a), 0);
        chk($sformatf("fs_busy%0d", k), 32'(busy_a), 1);
        chk($sformatf("fs_own%0d", k), 32'(own_a), 2);
      end else begin
        chk($sformatf("fs_gnt%0d", k), 32'(gnt_a), 32'h4);
        chk($sformatf("fs_busy%0d", k), 32'(busy_a), (k == 0 || k == 7) ? 0 : 1);
      end
      if (k == 7) chk("fs_words", 32'(fifo_cnt), 4);
      tick();
    end
    full_a = 0;

    // 5. owner drop, waiting requester granted with no bubble
    do_reset();
    req_a = 4'b1010; #1;
    chk("od_g0", 32'(gnt_a), 32'h2); tick();
    chk("od_g1", 32'(gnt_a), 32'h2); tick();
    req_a = 4'b1000; #1;
    chk("od_g2", 32'(gnt_a), 32'h8);
    chk("od_din2", 32'(din_a), 32'hA3);
    chk("od_own2", 32'(own_a), 1);
    tick();
    chk("od_g3", 32'(gnt_a), 32'h8);
    chk("od_own3", 32'(own_a), 3);
    chk("od_busy3", 32'(busy_a), 1);

    // 6. reset mid-burst
    do_reset();
    req_a = 4'b0110; #1;
    chk("rm_g0", 32'(gnt_a), 32'h2); tick();
    chk("rm_g1", 32'(gnt_a), 32'h2); tick();
    rst_n = 0; #1;
    chk("rm_gnt", 32'(gnt_a), 0);
    chk("rm_wr", 32'(wr_a), 0);
    chk("rm_din", 32'(din_a), 0);
    chk("rm_busy", 32'(busy_a), 0);
    chk("rm_cnt", 32'(fifo_cnt), 0);
    tick();
    rst_n = 1; req_a = 4'b1111; #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rm_post%0d", k), 32'(gnt_a), (k < 4) ? 32'h1 : 32'h2);
      tick();
    end
    chk("rm_words", 32'(fifo_cnt), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
